// File: rtl/sprite_anim_ctrl.sv
// sprite_anim_ctrl: per-frame latched sprite animation sequencer and shared sprite ROM address pipeline
module sprite_anim_ctrl #(
  parameter int SPRITE_W   = 100,
  parameter int SPRITE_H   = 100,
  parameter int MAX_FRAMES = 4,
  parameter int NF_IDLE    = 4,
  parameter int NF_MOVE    = 4,
  parameter int NF_ATK     = 2,
  parameter int FRAME_HOLD = 6,
  parameter int ADDR_W     = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic [3:0]        player_state,
  input  logic [9:0]        posx,
  input  logic [9:0]        posy,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  output logic              sprite_hit,
  output logic [1:0]        anim_frame,
  output logic [2:0]        anim_slot
);
  localparam int HW = $clog2(FRAME_HOLD + 1);
  logic [2:0]        slot_new, anim_slot_q, anim_slot_d;
  logic [1:0]        anim_frame_q, anim_frame_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [9:0]        posx_l_q, posx_l_d, posy_l_q, posy_l_d;
  logic [3:0]        nf;
  logic              inside_q, inside_d;
  logic [9:0]        dx_q, dx_d, dy_q, dy_d;
  logic [10:0]       px, py, lx, ly;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d, addr;
  logic              rom_en_q, rom_en_d, sprite_hit_q, sprite_hit_d;
  // map player state to ROM slot; unused states fall back to idle
  always_comb begin
    slot_new = player_state == 4'd0 ? 3'd0 :
               (player_state == 4'd1 || player_state == 4'd2) ? 3'd1 :
               player_state == 4'd3 ? 3'd2 :
               player_state == 4'd4 ? 3'd3 :
               player_state == 4'd5 ? 3'd4 : 3'd0;
  end
  // once-per-frame latch of slot/position and animation frame stepping
  always_comb begin
    nf = anim_slot_q == 3'd0 ? 4'(NF_IDLE) : anim_slot_q == 3'd1 ? 4'(NF_MOVE) : 4'(NF_ATK);
    anim_slot_d  = anim_slot_q;
    anim_frame_d = anim_frame_q;
    hold_cnt_d   = hold_cnt_q;
    posx_l_d     = posx_l_q;
    posy_l_d     = posy_l_q;
    if (frame_tick) begin
      anim_slot_d = slot_new;
      posx_l_d    = posx;
      posy_l_d    = posy;
      if (slot_new != anim_slot_q) begin
        anim_frame_d = 2'd0;
        hold_cnt_d   = '0;
      end else if (hold_cnt_q == HW'(FRAME_HOLD - 1)) begin
        hold_cnt_d   = '0;
        anim_frame_d = ({2'b00, anim_frame_q} == nf - 4'd1) ? 2'd0 : anim_frame_q + 2'd1;
      end else begin
        hold_cnt_d = hold_cnt_q + HW'(1);
      end
    end
  end
  // address pipeline: inside test and offsets, then ROM address, then hit aligned to ROM data
  always_comb begin
    px       = {1'b0, pixel_x};
    py       = {1'b0, pixel_y};
    lx       = {1'b0, posx_l_q};
    ly       = {1'b0, posy_l_q};
    inside_d = px >= lx && px < lx + 11'(SPRITE_W) && py >= ly && py < ly + 11'(SPRITE_H);
    dx_d     = pixel_x - posx_l_q;
    dy_d     = pixel_y - posy_l_q;
    addr     = (ADDR_W'(anim_slot_q) * ADDR_W'(MAX_FRAMES) + ADDR_W'(anim_frame_q)) * ADDR_W'(SPRITE_W * SPRITE_H)
             + ADDR_W'(dy_q) * ADDR_W'(SPRITE_W) + ADDR_W'(dx_q);
    rom_addr_d   = inside_q ? addr : rom_addr_q;
    rom_en_d     = inside_q;
    sprite_hit_d = rom_en_q;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      anim_slot_q  <= '0;
      anim_frame_q <= '0;
      hold_cnt_q   <= '0;
      posx_l_q     <= '0;
      posy_l_q     <= '0;
      inside_q     <= 1'b0;
      dx_q         <= '0;
      dy_q         <= '0;
      rom_addr_q   <= '0;
      rom_en_q     <= 1'b0;
      sprite_hit_q <= 1'b0;
    end else begin
      anim_slot_q  <= anim_slot_d;
      anim_frame_q <= anim_frame_d;
      hold_cnt_q   <= hold_cnt_d;
      posx_l_q     <= posx_l_d;
      posy_l_q     <= posy_l_d;
      inside_q     <= inside_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      rom_addr_q   <= rom_addr_d;
      rom_en_q     <= rom_en_d;
      sprite_hit_q <= sprite_hit_d;
    end
  end
  assign rom_addr   = rom_addr_q;
  assign rom_en     = rom_en_q;
  assign sprite_hit = sprite_hit_q;
  assign anim_frame = anim_frame_q;
  assign anim_slot  = anim_slot_q;
endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// tb_sprite_anim_ctrl: randomized scoreboard bench for sprite_anim_ctrl against a frame-level reference model
module tb_sprite_anim_ctrl;
  logic        clk, rst, frame_tick;
  logic [3:0]  player_state;
  logic [9:0]  posx, posy, pixel_x, pixel_y;
  logic [17:0] rom_addr;
  logic        rom_en, sprite_hit;
  logic [1:0]  anim_frame;
  logic [2:0]  anim_slot;

  sprite_anim_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .player_state(player_state),
    .posx(posx), .posy(posy), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .rom_addr(rom_addr), .rom_en(rom_en), .sprite_hit(sprite_hit),
    .anim_frame(anim_frame), .anim_slot(anim_slot)
  );

  typedef struct {int due; int kind; int en; int addr;} exp_t;
  exp_t q[$];
  int cyc = 0, passed = 0, total = 0;
  int slot_m, frame_m, hold_m, pxl_m, pyl_m;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
  endtask

  function automatic int slot_of(input int st);
    case (st)
      0: return 0;
      1, 2: return 1;
      3: return 2;
      4: return 3;
      5: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int nframes(input int s);
    return s == 0 ? 4 : s == 1 ? 4 : 2;
  endfunction

  function automatic int clip(input int v);
    return v < 0 ? 0 : v > 1023 ? 1023 : v;
  endfunction

  // monitor: compare each queued expectation in the cycle it is due
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.kind == 0) begin
        check("rom_en", rom_en, e.en);
        if (e.en != 0) check("rom_addr", rom_addr, e.addr);
      end else check("sprite_hit", sprite_hit, e.en);
    end
  end

  task automatic model_reset();
    slot_m = 0; frame_m = 0; hold_m = 0; pxl_m = 0; pyl_m = 0;
  endtask

  // one pixel per cycle; latch inputs scrambled to show mid-frame changes are ignored
  task automatic pix(input int x, input int y);
    int ins;
    ins = (x >= pxl_m && x < pxl_m + 100 && y >= pyl_m && y < pyl_m + 100) ? 1 : 0;
    pixel_x = 10'(x); pixel_y = 10'(y);
    posx = 10'($urandom); posy = 10'($urandom); player_state = 4'($urandom);
    q.push_back('{cyc + 2, 0, ins, (slot_m * 4 + frame_m) * 10000 + (y - pyl_m) * 100 + (x - pxl_m)});
    q.push_back('{cyc + 3, 1, ins, 0});
    @(negedge clk);
  endtask

  task automatic tick(input int st, input int x, input int y);
    int ns;
    player_state = 4'(st); posx = 10'(x); posy = 10'(y); frame_tick = 1;
    pixel_x = 10'($urandom); pixel_y = 10'($urandom);
    @(negedge clk);
    frame_tick = 0;
    ns = slot_of(st);
    if (ns != slot_m) begin
      slot_m = ns; frame_m = 0; hold_m = 0;
    end else if (hold_m == 5) begin
      hold_m = 0;
      frame_m = (frame_m == nframes(slot_m) - 1) ? 0 : frame_m + 1;
    end else hold_m++;
    pxl_m = x; pyl_m = y;
    check("anim_slot", anim_slot, slot_m);
    check("anim_frame", anim_frame, frame_m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1; frame_tick = 0; player_state = 0; posx = 0; posy = 0; pixel_x = 0; pixel_y = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst rom_addr", rom_addr, 0);
    check("rst rom_en", rom_en, 0);
    check("rst sprite_hit", sprite_hit, 0);
    check("rst anim_frame", anim_frame, 0);
    check("rst anim_slot", anim_slot, 0);
    rst = 0;
    pix(5, 5);
    pix(99, 99);
    pix(100, 5);
    tick(3, 200, 100);
    pix(210, 120);
    pix(199, 120);
    pix(299, 199);
    repeat (30) tick(0, 0, 0);
    repeat (14) tick(4, 50, 50);
    pix(60, 60);
    for (int i = 0; i < 30 && !(slot_m == 0 && frame_m == 3); i++) tick(0, 0, 0);
    check("idle frame 3 reached", anim_frame, 3);
    tick(1, 10, 10);
    tick(2, 10, 10);
    pix(20, 30);
    tick(9, 600, 400);
    pix(639, 479);
    pix(599, 479);
    pix(600, 400);
    tick(0, 300, 200);
    for (int x = 250; x <= 450; x++) pix(x, 250);
    repeat (30) begin
      int st, nt, bx, by;
      st = $urandom_range(0, 15);
      tick(st, $urandom_range(0, 700), $urandom_range(0, 500));
      nt = $urandom_range(0, 8);
      for (int k = 0; k < nt; k++) tick(st, pxl_m, pyl_m);
      bx = pxl_m; by = pyl_m;
      repeat (20) pix(clip(bx + $urandom_range(0, 140) - 20), clip(by + $urandom_range(0, 140) - 20));
    end
    tick(5, 100, 100);
    pixel_x = 150; pixel_y = 150;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("midrst rom_en", rom_en, 0);
    check("midrst sprite_hit", sprite_hit, 0);
    check("midrst rom_addr", rom_addr, 0);
    check("midrst anim_slot", anim_slot, 0);
    check("midrst anim_frame", anim_frame, 0);
    rst = 0;
    model_reset();
    pix(5, 5);
    pix(150, 150);
    repeat (5) @(negedge clk);
    check("scoreboard drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
